// File: rtl/vga_vblank_write_sched.sv
// vga_vblank_write_sched: queues Avalon register writes and releases them to the display bank only during vertical blanking
module vga_vblank_write_sched #(
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int VACTIVE = 480
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     chipselect,
  input  logic                     write,
  input  logic [ADDR_W-1:0]        address,
  input  logic [DATA_W-1:0]        writedata,
  input  logic [9:0]               vcount,
  output logic                     upd_valid,
  output logic [ADDR_W-1:0]        upd_addr,
  output logic [DATA_W-1:0]        upd_data,
  input  logic                     upd_ready,
  input  logic                     clr_overflow,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_full,
  output logic                     overflow,
  output logic [7:0]               drop_count,
  output logic                     commit_done
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [9:0] VA = 10'(VACTIVE);
  typedef enum logic {S_WAIT, S_DRAIN} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic vb_q, vb_d, overflow_q, overflow_d, commit_q, commit_d;
  logic [7:0] drop_q, drop_d;
  logic [ADDR_W+DATA_W-1:0] mem_q [DEPTH];
  logic push, accept, drop, pop, vb, empty_next;
  always_comb begin
    push = chipselect & write;
    accept = push & (count_q != FULL);
    drop = push & ~accept;
    upd_valid = (state_q == S_DRAIN) & (count_q != '0);
    pop = upd_valid & upd_ready;
    vb = vcount >= VA;
    vb_d = vb;
    empty_next = count_q == CW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(accept);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d = count_q + CW'(accept) - CW'(pop);
    commit_d = (state_q == S_DRAIN) & empty_next;
    state_d = state_q == S_WAIT ? ((vb & ~vb_q) ? S_DRAIN : S_WAIT)
            : ((empty_next | (~vb & ~(upd_valid & ~upd_ready))) ? S_WAIT : S_DRAIN);
    overflow_d = drop | (overflow_q & ~clr_overflow);
    drop_d = clr_overflow ? {7'd0, drop} : drop_q + 8'(drop & (drop_q != 8'hff));
    {upd_addr, upd_data} = mem_q[rd_ptr_q];
    fifo_count = count_q;
    fifo_full = count_q == FULL;
    overflow = overflow_q;
    drop_count = drop_q;
    commit_done = commit_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_WAIT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      vb_q <= 1'b1;
      overflow_q <= 1'b0;
      commit_q <= 1'b0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      vb_q <= vb_d;
      overflow_q <= overflow_d;
      commit_q <= commit_d;
      drop_q <= drop_d;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= {address, writedata};
  end
endmodule

// File: tb/tb_vga_vblank_write_sched.sv
// tb_vga_vblank_write_sched: directed table and sequence checks of the vblank write scheduler
module tb_vga_vblank_write_sched;
  logic clk = 1'b0, reset = 1'b1, chipselect = 1'b0, write = 1'b0;
  logic [3:0] address = '0;
  logic [7:0] writedata = '0;
  logic [9:0] vcount = 10'd100;
  logic upd_valid, upd_ready = 1'b1, clr_overflow = 1'b0;
  logic [3:0] upd_addr;
  logic [7:0] upd_data;
  logic [3:0] fifo_count;
  logic fifo_full, overflow, commit_done;
  logic [7:0] drop_count;
  int errs = 0, total = 0;
  typedef struct {
    int cs, wr, a, d, vc, rd, cl, cnt, vld, ea, ed, ovf, drop, cd;
  } vec_t;
  vec_t vq[$];
  int mq[$];
  vga_vblank_write_sched dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
    .address(address), .writedata(writedata), .vcount(vcount),
    .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_data(upd_data),
    .upd_ready(upd_ready), .clr_overflow(clr_overflow), .fifo_count(fifo_count),
    .fifo_full(fifo_full), .overflow(overflow), .drop_count(drop_count),
    .commit_done(commit_done)
  );
  always #5 clk = ~clk;
  function automatic void add(input int cs, wr, a, d, vc, rd, cl, cnt, vld, ea, ed, ovf, drop, cd);
    vec_t r;
    r = '{cs, wr, a, d, vc, rd, cl, cnt, vld, ea, ed, ovf, drop, cd};
    vq.push_back(r);
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask
  task automatic ex(input string t, input int cnt, vld, ea, ed, ovf, drop, cd);
    chk({t, " count"}, 32'(fifo_count), cnt);
    chk({t, " valid"}, 32'(upd_valid), vld);
    chk({t, " full"}, 32'(fifo_full), 32'(cnt == 8));
    chk({t, " overflow"}, 32'(overflow), ovf);
    chk({t, " drop"}, 32'(drop_count), drop);
    chk({t, " commit"}, 32'(commit_done), cd);
    if (vld != 0) begin
      chk({t, " addr"}, 32'(upd_addr), ea);
      chk({t, " data"}, 32'(upd_data), ed);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic cyc(input int c, w, a, d, vc, rd, cl);
    chipselect = c[0];
    write = w[0];
    address = 4'(a);
    writedata = 8'(d);
    vcount = 10'(vc);
    upd_ready = rd[0];
    clr_overflow = cl[0];
    step();
  endtask
  initial begin
    add(1,0,5,'hAA,100,1,0, 0,0,0,0,0,0,0);
    add(0,1,5,'hAA,100,1,0, 0,0,0,0,0,0,0);
    add(1,1,0,'hFF,100,1,0, 1,0,0,0,0,0,0);
    add(1,1,1,'h00,100,1,0, 2,0,0,0,0,0,0);
    add(1,1,2,'h80,100,1,0, 3,0,0,0,0,0,0);
    add(0,0,0,0,480,1,0, 3,1,0,'hFF,0,0,0);
    add(0,0,0,0,480,1,0, 2,1,1,'h00,0,0,0);
    add(0,0,0,0,480,1,0, 1,1,2,'h80,0,0,0);
    add(0,0,0,0,480,1,0, 0,0,0,0,0,0,1);
    add(0,0,0,0,480,1,0, 0,0,0,0,0,0,0);
    add(0,0,0,0,100,1,0, 0,0,0,0,0,0,0);
    for (int i = 0; i < 8; i++) add(1,1,i,'h10+i,100,1,0, i+1,0,0,0,0,0,0);
    add(1,1,8,'h18,100,1,0, 8,0,0,0,1,1,0);
    add(1,1,9,'h19,100,1,0, 8,0,0,0,1,2,0);
    add(0,0,0,0,480,1,0, 8,1,0,'h10,1,2,0);
    for (int k = 0; k < 7; k++) add(0,0,0,0,480,1,0, 7-k,1,k+1,'h11+k,1,2,0);
    add(0,0,0,0,480,1,0, 0,0,0,0,1,2,1);
    add(0,0,0,0,480,1,1, 0,0,0,0,0,0,0);
    #1;
    ex("reset", 0,0,0,0,0,0,0);
    step();
    step();
    reset = 1'b0;
    foreach (vq[i]) begin
      cyc(vq[i].cs, vq[i].wr, vq[i].a, vq[i].d, vq[i].vc, vq[i].rd, vq[i].cl);
      ex($sformatf("row%0d", i), vq[i].cnt, vq[i].vld, vq[i].ea, vq[i].ed, vq[i].ovf, vq[i].drop, vq[i].cd);
    end
    cyc(0,0,0,0,100,0,0);
    cyc(1,1,'hA,'hA0,100,0,0);
    cyc(1,1,'hB,'hB1,100,0,0);
    cyc(1,1,'hC,'hC2,100,0,0);
    ex("T3 queued", 3,0,0,0,0,0,0);
    cyc(0,0,0,0,480,0,0);
    ex("T3 start", 3,1,'hA,'hA0,0,0,0);
    for (int k = 0; k < 5; k++) begin
      cyc(0,0,0,0,480,0,0);
      ex($sformatf("T3 stall%0d", k), 3,1,'hA,'hA0,0,0,0);
    end
    cyc(0,0,0,0,480,1,0);
    ex("T3 pop1", 2,1,'hB,'hB1,0,0,0);
    cyc(0,0,0,0,480,1,0);
    ex("T3 pop2", 1,1,'hC,'hC2,0,0,0);
    cyc(0,0,0,0,480,1,0);
    ex("T3 done", 0,0,0,0,0,0,1);
    cyc(0,0,0,0,100,1,0);
    for (int i = 0; i < 8; i++) cyc(1,1,i,'h40+i,100,1,0);
    ex("T4 full", 8,0,0,0,0,0,0);
    for (int k = 0; k < 256; k++) cyc(1,1,15,'hEE,100,1,0);
    ex("T4 saturate", 8,0,0,0,1,255,0);
    cyc(1,1,15,'hEE,100,1,1);
    ex("T4 clr+drop", 8,0,0,0,1,1,0);
    cyc(0,0,0,0,100,1,1);
    ex("T4 clr", 8,0,0,0,0,0,0);
    cyc(0,0,0,0,480,1,0);
    ex("T4 start", 8,1,0,'h40,0,0,0);
    cyc(0,0,0,0,480,1,0);
    ex("T4 pop0", 7,1,1,'h41,0,0,0);
    cyc(0,0,0,0,480,1,0);
    ex("T4 pop1", 6,1,2,'h42,0,0,0);
    cyc(0,0,0,0,524,0,0);
    ex("T4 stall524", 6,1,2,'h42,0,0,0);
    for (int k = 0; k < 3; k++) begin
      cyc(0,0,0,0,0,0,0);
      ex($sformatf("T4 stall_post%0d", k), 6,1,2,'h42,0,0,0);
    end
    cyc(0,0,0,0,0,1,0);
    ex("T4 last", 5,0,0,0,0,0,0);
    cyc(0,0,0,0,100,1,0);
    ex("T4 idle", 5,0,0,0,0,0,0);
    cyc(0,0,0,0,480,1,0);
    ex("T4 frame2", 5,1,3,'h43,0,0,0);
    for (int k = 0; k < 4; k++) begin
      cyc(0,0,0,0,480,1,0);
      ex($sformatf("T4 drain%0d", k), 4-k,1,4+k,'h44+k,0,0,0);
    end
    cyc(0,0,0,0,480,1,0);
    ex("T4 done", 0,0,0,0,0,0,1);
    cyc(0,0,0,0,100,1,0);
    for (int i = 0; i < 4; i++) begin
      cyc(1,1,i,'h60+i,100,1,0);
      mq.push_back((i << 8) | ('h60 + i));
    end
    cyc(0,0,0,0,480,1,0);
    ex("T5 start", 4,1,mq[0]>>8,mq[0]&255,0,0,0);
    for (int k = 0; k < 6; k++) begin
      cyc(1,1,4+k,'h64+k,480,1,0);
      void'(mq.pop_front());
      mq.push_back(((4 + k) << 8) | ('h64 + k));
      ex($sformatf("T5 pp%0d", k), 4,1,mq[0]>>8,mq[0]&255,0,0,0);
    end
    for (int k = 0; k < 3; k++) begin
      cyc(0,0,0,0,480,1,0);
      void'(mq.pop_front());
      ex($sformatf("T5 drain%0d", k), mq.size(),1,mq[0]>>8,mq[0]&255,0,0,0);
    end
    cyc(0,0,0,0,480,1,0);
    ex("T5 done", 0,0,0,0,0,0,1);
    cyc(0,0,0,0,100,1,0);
    for (int i = 0; i < 3; i++) cyc(1,1,i,'h70+i,100,1,0);
    cyc(0,0,0,0,480,1,0);
    ex("T6 start", 3,1,0,'h70,0,0,0);
    cyc(0,0,0,0,480,1,0);
    ex("T6 pop", 2,1,1,'h71,0,0,0);
    #2 reset = 1'b1;
    #1;
    ex("T6 async", 0,0,0,0,0,0,0);
    step();
    step();
    #3 reset = 1'b0;
    step();
    cyc(1,1,9,'h99,480,1,0);
    ex("T6 post", 1,0,0,0,0,0,0);
    for (int k = 0; k < 3; k++) begin
      cyc(0,0,0,0,480,1,0);
      ex($sformatf("T6 hold%0d", k), 1,0,0,0,0,0,0);
    end
    cyc(0,0,0,0,100,1,0);
    cyc(0,0,0,0,480,1,0);
    ex("T6 next", 1,1,9,'h99,0,0,0);
    cyc(0,0,0,0,480,1,0);
    ex("T6 done", 0,0,0,0,0,0,1);
    cyc(0,0,0,0,100,1,0);
    cyc(0,0,0,0,480,1,0);
    ex("tick drain", 0,0,0,0,0,0,0);
    cyc(0,0,0,0,480,1,0);
    ex("tick pulse", 0,0,0,0,0,0,1);
    cyc(0,0,0,0,480,1,0);
    ex("tick end", 0,0,0,0,0,0,0);
    $display("Result: errors=%0d of %0d checks", errs, total);
    $finish;
  end
endmodule
